// File: rtl/tekram_pkg.sv
// tekram_pkg: shared constants, state encoding and helpers for the tekram_be
// scratch RAM and its storage array.
//   RDW_*   : write-cycle output modes (RDW_MODE parameter values)
//   state_t : controller state (post-reset clear, normal run, requested clear)
//   nbytes  : number of byte lanes in a data word
package tekram_pkg;

    localparam int RDW_NONE = 0;  // writes produce no output
    localparam int RDW_OLD  = 1;  // writes return the pre-write word
    localparam int RDW_NEW  = 2;  // writes return the merged post-write word

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_CLEAR
    } state_t;

    function automatic int nbytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/tekram_array.sv
// tekram_array: DEPTH x DATA_WIDTH storage with per-byte write enables and a
// registered read port. No control logic; the caller guarantees addr < DEPTH
// whenever we or rd_en is active.
//   clk   : clock
//   addr  : word address shared by read and write
//   we    : per-byte write enable, we[i] covers wdata[8i+7:8i]
//   wdata : write data
//   rd_en : load rdata this cycle
//   rdata : registered read data; with WRITE_FIRST=1, written bytes are
//           forwarded from wdata, otherwise the pre-write byte is returned
module tekram_array
    import tekram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = nbytes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i])
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            if (rd_en)
                rdata[8*i +: 8] <= (WRITE_FIRST && we[i]) ? wdata[8*i +: 8]
                                                          : mem[addr][8*i +: 8];
        end
    end

endmodule

// File: rtl/tekram_be.sv
// tekram_be: single-port synchronous scratch RAM with byte-enable writes,
// registered read + dout_valid, selectable read-during-write output, range
// checking and a clear engine that zeroes the array after reset or on clr.
//   clk, rst   : clock, synchronous active-high reset
//   cs, wr     : access request, 1 = write / 0 = read
//   be, addr   : byte enables (writes), word address
//   din        : write data
//   dout       : registered read data (holds while dout_valid=0)
//   dout_valid : 1-cycle pulse per produced result
//   ready      : accesses are accepted only while high
//   clr        : request a full clear (honoured in ST_RUN only)
//   err        : 1-cycle pulse, accepted access had addr >= DEPTH
module tekram_be
    import tekram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int RDW_MODE       = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    wr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    ready,
    input  logic                    clr,
    output logic                    err
);

    localparam int NB = nbytes(DATA_WIDTH);
    // Counter is one bit wider than the address so DEPTH = 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   cnt, cnt_nx;
    logic                  acc, in_rng, rd_out, sweeping;
    logic                  zero_q;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [NB-1:0]         arr_we;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;

    assign acc      = cs & ready;
    assign in_rng   = {1'b0, addr} < DEPTH_W;
    // Reads always produce a result; writes only when a RDW output mode is set.
    assign rd_out   = acc & (~wr | (RDW_MODE != RDW_NONE));
    assign sweeping = (state != ST_RUN);

    // The sweep owns the array port; ready=0 keeps accesses off it meanwhile.
    assign arr_addr  = sweeping ? cnt[ADDR_WIDTH-1:0] : addr;
    assign arr_we    = sweeping ? '1 : ((acc & wr & in_rng) ? be : '0);
    assign arr_wdata = sweeping ? '0 : din;

    tekram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .WRITE_FIRST(RDW_MODE == RDW_NEW)
    ) u_array (
        .clk  (clk),
        .addr (arr_addr),
        .we   (arr_we),
        .wdata(arr_wdata),
        .rd_en(rd_out & in_rng),
        .rdata(arr_rdata)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RUN: begin
                if (clr) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                end
            end
            ST_INIT, ST_CLEAR: begin
                if (cnt == CNT_LAST) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_INIT;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            cnt        <= '0;
            ready      <= 1'b0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            ready      <= (state_nx == ST_RUN);
            dout_valid <= rd_out;
            err        <= acc & ~in_rng;
            // Out-of-range results read as zero; the array register is left
            // untouched so dout still holds across idle cycles.
            if (rd_out)
                zero_q <= ~in_rng;
        end
    end

    assign dout = zero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_tekram_be.sv
module tb_tekram_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, wr = 1'b0, clr = 1'b0;
    logic [1:0]  be = '0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;

    logic [15:0] dout [3];
    logic        dv [3];
    logic        err [3];
    logic        rdy [3];

    int dep  [3] = '{16, 16, 12};
    int mode [3] = '{0, 1, 2};

    logic [15:0] m [3][16];
    logic [15:0] sbq [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tekram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16), .RDW_MODE(0), .CLEAR_ON_RESET(1'b1)) u0 (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .be(be), .addr(addr), .din(din),
        .dout(dout[0]), .dout_valid(dv[0]), .ready(rdy[0]), .clr(clr), .err(err[0]));
    tekram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16), .RDW_MODE(1), .CLEAR_ON_RESET(1'b1)) u1 (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .be(be), .addr(addr), .din(din),
        .dout(dout[1]), .dout_valid(dv[1]), .ready(rdy[1]), .clr(clr), .err(err[1]));
    tekram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12), .RDW_MODE(2), .CLEAR_ON_RESET(1'b1)) u2 (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .be(be), .addr(addr), .din(din),
        .dout(dout[2]), .dout_valid(dv[2]), .ready(rdy[2]), .clr(clr), .err(err[2]));

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 16; a++)
                m[k][a] = '0;
    endtask

    // One access; expected results are pushed before the edge and popped
    // after it, in DUT order.
    task automatic access(input string tag, input bit w, input logic [1:0] b,
                          input logic [3:0] a, input logic [15:0] d, input bit c);
        bit          ev [3];
        bit          ee [3];
        logic [15:0] old, nw;
        @(negedge clk);
        cs = 1'b1; wr = w; be = b; addr = a; din = d; clr = c;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            ee[k] = 1'b0;
            if (rdy[k]) begin
                ee[k] = (a >= dep[k]);
                if (!w) begin
                    ev[k] = 1'b1;
                    sbq.push_back(ee[k] ? 16'h0000 : m[k][a]);
                end else begin
                    old = m[k][a];
                    nw  = old;
                    for (int i = 0; i < 2; i++)
                        if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
                    if (!ee[k]) m[k][a] = nw;
                    if (mode[k] != 0) begin
                        ev[k] = 1'b1;
                        sbq.push_back(ee[k] ? 16'h0000 : (mode[k] == 1 ? old : nw));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk({tag, " valid"}, k, {15'd0, dv[k]}, {15'd0, ev[k]});
            chk({tag, " err"}, k, {15'd0, err[k]}, {15'd0, ee[k]});
            if (ev[k]) chk({tag, " data"}, k, dout[k], sbq.pop_front());
        end
        if (c) zero_model();
    endtask

    // Counts edges until each DUT raises ready; optional clr / cs pulses.
    task automatic wait_ready(input string tag, input int clr_at, input int cs_at);
        int rise [3];
        for (int k = 0; k < 3; k++) rise[k] = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            rst = 1'b0;
            clr = (n == clr_at);
            cs  = (n == cs_at);
            wr  = 1'b0;
            addr = 4'd0;
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rise[k] == 0 && rdy[k]) rise[k] = n;
                if (n == cs_at) begin
                    chk({tag, " dropped valid"}, k, {15'd0, dv[k]}, 16'd0);
                    chk({tag, " dropped err"}, k, {15'd0, err[k]}, 16'd0);
                end
            end
            if (rise[0] != 0 && rise[1] != 0 && rise[2] != 0) break;
        end
        @(negedge clk);
        cs = 1'b0; clr = 1'b0;
        for (int k = 0; k < 3; k++)
            chk({tag, " ready cycles"}, k, 16'(rise[k]), 16'(dep[k]));
    endtask

    initial begin
        zero_model();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst ready", k, {15'd0, rdy[k]}, 16'd0);
            chk("rst valid", k, {15'd0, dv[k]}, 16'd0);
            chk("rst err", k, {15'd0, err[k]}, 16'd0);
            chk("rst dout", k, dout[k], 16'd0);
        end
        wait_ready("init", 0, 0);

        for (int a = 0; a < 16; a++) access("init read", 1'b0, 2'b00, 4'(a), 16'h0, 1'b0);

        access("be wr full", 1'b1, 2'b11, 4'd3, 16'h1234, 1'b0);
        access("be wr low", 1'b1, 2'b01, 4'd3, 16'hABCD, 1'b0);
        access("be rd", 1'b0, 2'b00, 4'd3, 16'h0, 1'b0);
        access("be wr none", 1'b1, 2'b00, 4'd3, 16'h5555, 1'b0);
        access("be rd2", 1'b0, 2'b00, 4'd3, 16'h0, 1'b0);

        access("rdw seed", 1'b1, 2'b11, 4'd5, 16'h1111, 1'b0);
        access("rdw wr", 1'b1, 2'b11, 4'd5, 16'h2222, 1'b0);
        access("rdw rd", 1'b0, 2'b00, 4'd5, 16'h0, 1'b0);

        access("oor wr", 1'b1, 2'b11, 4'd13, 16'hFFFF, 1'b0);
        access("oor rd", 1'b0, 2'b00, 4'd13, 16'h0, 1'b0);
        access("post oor rd", 1'b0, 2'b00, 4'd5, 16'h0, 1'b0);
        for (int a = 0; a < 16; a++) access("scan", 1'b0, 2'b00, 4'(a), 16'h0, 1'b0);

        access("clr wr", 1'b1, 2'b11, 4'd2, 16'h5A5A, 1'b1);
        wait_ready("clr", 5, 0);
        access("clr rd2", 1'b0, 2'b00, 4'd2, 16'h0, 1'b0);
        access("clr rd3", 1'b0, 2'b00, 4'd3, 16'h0, 1'b0);

        access("pre rst wr", 1'b1, 2'b10, 4'd7, 16'hC3C3, 1'b0);
        @(negedge clk);
        cs = 1'b0; clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        zero_model();
        wait_ready("rst sweep", 0, 3);
        access("rst rd7", 1'b0, 2'b00, 4'd7, 16'h0, 1'b0);
        access("rst rd5", 1'b0, 2'b00, 4'd5, 16'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tekram_be.md
Name: tekram_be

Overview:
Parametrised single-port synchronous RAM and the successor to the team's basic tekram. It replaces the tristate bus with separate din/dout, and adds the following:
- byte-enable writes
- a registered read with a dout_valid flag
- a selectable read-during-write mode
- a hardware clear engine that zeroes the array after reset or on request

It sits behind the bus-side register/DMA logic as a generic scratch memory.

Parameters:
ADDR_WIDTH, 4, address bits
DATA_WIDTH, 16, word width; must be a multiple of 8
DEPTH, 16, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
RDW_MODE, 0, write-cycle output: 0 = no output, 1 = old word (read-first), 2 = new merged word (write-first)
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = go straight to RUN

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cs  in  1  access request
wr  in  1  1 = write, 0 = read (qualified by cs)
be  in  DATA_WIDTH/8  byte enables for writes; be[i] covers din[8i+7:8i]
addr  in  ADDR_WIDTH  word address
din  in  DATA_WIDTH  write data
dout  out  DATA_WIDTH  registered read data
dout_valid  out  1  dout updated this cycle (1-cycle pulse per read)
ready  out  1  block accepts accesses
clr  in  1  request full-array clear (sampled in RUN only)
err  out  1  1-cycle pulse: accepted access had addr >= DEPTH

Behaviour:
- Reset (rst=1 at a posedge):
  - dout=0, dout_valid=0, err=0, ready=0.
  - Clear counter is set to 0.
  - State goes to ST_INIT if CLEAR_ON_RESET=1, else ST_RUN; ready rises the cycle after rst deasserts.
- States:
  - ST_INIT (post-reset clear) and ST_CLEAR (requested clear): one word per cycle is written to 0 at counter address 0..DEPTH-1, taking exactly DEPTH cycles. Then state -> ST_RUN and ready=1 on the following cycle. ready=0 throughout.
  - ST_RUN: normal accesses.
- Acceptance: an access is accepted at a posedge where cs=1 and ready=1. If cs=1 while ready=0, the access is silently dropped: no err, no dout_valid.
- Read accepted at edge N: dout = mem[addr] and dout_valid=1, both registered at edge N (visible during cycle N..N+1). Latency is 1 clock. Back-to-back reads give one result per cycle.
  - dout holds its last value while dout_valid=0.
- Write accepted: only the bytes with be[i]=1 are updated; be=0 leaves memory unchanged. Write data is visible to a read at the next cycle.
- Write output depends on RDW_MODE:
  - RDW_MODE=0: dout_valid stays 0.
  - RDW_MODE=1: dout = pre-write word, dout_valid=1.
  - RDW_MODE=2: dout = merged post-write word, dout_valid=1.
- Out-of-range access (addr >= DEPTH) while accepted:
  - err=1 for one cycle.
  - Writes are discarded.
  - Reads return dout=0 with dout_valid=1.
  - Writes with RDW_MODE!=0 also return 0 with dout_valid=1.
- clr in ST_RUN:
  - ready drops at the next edge and the state enters ST_CLEAR.
  - A cs access in the same cycle as clr is still accepted and completes first: its write lands, then is cleared; its read returns pre-clear data.
- clr in ST_INIT or ST_CLEAR is ignored; the sweep is not restarted.
- rst during a sweep: the counter restarts at 0 (ST_INIT, or ST_RUN if CLEAR_ON_RESET=0). Contents are then undefined except where the sweep has covered them.
- Width rules: the counter is ADDR_WIDTH+1 bits so DEPTH = 2**ADDR_WIDTH terminates cleanly. The address comparison is unsigned.

Decomposition:
- tekram_pkg holds:
  - RDW_NONE/RDW_OLD/RDW_NEW constants
  - state enum ST_INIT, ST_RUN, ST_CLEAR
  - function nbytes(DATA_WIDTH)
- Sub-module tekram_array holds the DEPTH x DATA_WIDTH storage: per-byte write enable and a synchronous read port, with no control logic.
- tekram_be holds the FSM, clear counter, acceptance, range check and output registers.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=16: release rst -> ready=0 for exactly 16 cycles, then 1; reading addresses 0..15 returns 0x0000 each with dout_valid one cycle after acceptance.
- Byte enables: write 0x1234 with be=2'b11 to addr 3, then 0xABCD with be=2'b01 -> a read of addr 3 returns 0x12CD; a write with be=2'b00 leaves it at 0x12CD.
- RDW_MODE sweep: mem[5]=0x1111, then write 0x2222 to addr 5:
  - mode 0 -> dout_valid=0
  - mode 1 -> dout=0x1111, dout_valid=1
  - mode 2 -> dout=0x2222, dout_valid=1
- Out-of-range with DEPTH=12, ADDR_WIDTH=4: write 0xFFFF to addr 13 -> err pulses 1 cycle and no cell changes; a read of addr 13 -> dout=0, dout_valid=1, err=1.
- clr in the same cycle as a write of 0x5A5A to addr 2 -> ready=0 for DEPTH cycles; after that, a read of addr 2 returns 0. Pulsing clr again mid-sweep does not extend the sweep.
- rst asserted at sweep cycle 7 -> the sweep restarts and ready stays 0 for a full DEPTH cycles after rst deasserts. A cs pulse while ready=0 produces no dout_valid and no err.
